// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised RS-232 transmitter with a small write FIFO.
// Frames are start(0), DATA_BITS data bits LSB first, optional parity,
// STOP_BITS stop bits(1). Bit time is baud_div clk cycles (0/1 -> 2),
// sampled once per frame at the pop. Queued words go out back-to-back.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   wr_en       push wr_data this cycle (dropped when full)
//   wr_data     word to transmit
//   baud_div    clk cycles per bit
//   full/empty  FIFO status from the registered count
//   level       FIFO occupancy
//   overflow    one-cycle pulse, the cycle after a rejected write
//   busy        frame in progress
//   TxD         registered serial output, idles high
module uart_tx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 4,
  parameter int DIV_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_BITS-1:0]     wr_data,
  input  logic [DIV_W-1:0]         baud_div,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     busy,
  output logic                     TxD
);
  localparam int AW    = $clog2(DEPTH);
  localparam int IDX_W = 4;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  // ---------------- FIFO ----------------
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wrPtr, rdPtr;
  logic [AW:0]          count;
  logic                 push, pop;
  logic [DATA_BITS-1:0] headWord;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign level    = count;
  // Full is judged on the registered count, so a pop in the same cycle
  // does not make room for this write.
  assign push     = wr_en && !full;
  assign headWord = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && full;
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------- transmitter ----------------
  state_t               state, stateN;
  logic [DIV_W-1:0]     cnt, cntN, divQ, divN, divClamp;
  logic [IDX_W-1:0]     idx, idxN;
  logic [DATA_BITS-1:0] shift, shiftN;
  logic                 parQ, parN, txdQ, txdN, tick;

  assign divClamp = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
  assign tick     = (cnt == divQ - DIV_W'(1));
  assign busy     = (state != IDLE);
  assign TxD      = txdQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      divQ  <= DIV_W'(2);
      shift <= '0;
      parQ  <= 1'b0;
      txdQ  <= 1'b1;
    end else begin
      state <= stateN;
      cnt   <= cntN;
      idx   <= idxN;
      divQ  <= divN;
      shift <= shiftN;
      parQ  <= parN;
      txdQ  <= txdN;
    end
  end

  // txdN is the line value for the cycle after the edge, so TxD stays a
  // plain register and tracks the state it belongs to.
  always_comb begin
    stateN = state;
    cntN   = tick ? '0 : cnt + 1'b1;   // every bit boundary reloads
    idxN   = idx;
    divN   = divQ;
    shiftN = shift;
    parN   = parQ;
    txdN   = txdQ;
    pop    = 1'b0;

    case (state)
      IDLE: begin
        cntN = '0;
        txdN = 1'b1;
        if (!empty) begin
          pop    = 1'b1;
          shiftN = headWord;
          parN   = (^headWord) ^ (PARITY == 2);
          divN   = divClamp;
          idxN   = '0;
          stateN = START;
          txdN   = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          stateN = DATA;
          idxN   = '0;
          txdN   = shift[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (idx == IDX_W'(DATA_BITS - 1)) begin
            idxN = '0;
            if (PARITY != 0) begin
              stateN = PAR;
              txdN   = parQ;
            end else begin
              stateN = STOP;
              txdN   = 1'b1;
            end
          end else begin
            idxN   = idx + 1'b1;
            shiftN = shift >> 1;
            txdN   = shift[1];
          end
        end
      end
      PAR: begin
        if (tick) begin
          stateN = STOP;
          idxN   = '0;
          txdN   = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          if (idx == IDX_W'(STOP_BITS - 1)) begin
            idxN = '0;
            if (!empty) begin
              // Chain straight into the next frame with no idle cycle.
              pop    = 1'b1;
              shiftN = headWord;
              parN   = (^headWord) ^ (PARITY == 2);
              divN   = divClamp;
              stateN = START;
              txdN   = 1'b0;
            end else begin
              stateN = IDLE;
              txdN   = 1'b1;
            end
          end else begin
            idxN = idx + 1'b1;
          end
        end
      end
      default: begin
        stateN = IDLE;
        txdN   = 1'b1;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic [15:0] baud_div = 16'd4;
  logic [3:0]  txd, busy, full, empty, ovf;
  logic [2:0]  lvl [4];

  int nChk = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  // Four configurations share stimulus: 8N1, 8E2, 8O2, 5N1.
  localparam int DB [4] = '{8, 8, 8, 5};
  localparam int PM [4] = '{0, 1, 2, 0};
  localparam int SB [4] = '{1, 2, 2, 1};

  uart_tx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(4), .DIV_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .baud_div(baud_div),
    .full(full[0]), .empty(empty[0]), .level(lvl[0]), .overflow(ovf[0]), .busy(busy[0]), .TxD(txd[0]));
  uart_tx_fifo #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .DEPTH(4), .DIV_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .baud_div(baud_div),
    .full(full[1]), .empty(empty[1]), .level(lvl[1]), .overflow(ovf[1]), .busy(busy[1]), .TxD(txd[1]));
  uart_tx_fifo #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .DEPTH(4), .DIV_W(16)) u2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .baud_div(baud_div),
    .full(full[2]), .empty(empty[2]), .level(lvl[2]), .overflow(ovf[2]), .busy(busy[2]), .TxD(txd[2]));
  uart_tx_fifo #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .DEPTH(4), .DIV_W(16)) u3 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data[4:0]), .baud_div(baud_div),
    .full(full[3]), .empty(empty[3]), .level(lvl[3]), .overflow(ovf[3]), .busy(busy[3]), .TxD(txd[3]));

  // Reference: a word queue plus, per DUT, the list of line values still to
  // be shown for the frame in flight. A frame is built whole from the
  // framing rules when a word leaves the queue.
  logic [7:0] mq [4][$];
  bit         ln [4][$];
  logic [3:0] eTxd, eBusy, eOvf, eFull, eEmpty;
  logic [2:0] eLvl [4];

  always @(posedge clk or negedge rst_n) begin : model
    int pre, div;
    logic [7:0] w;
    bit p;
    if (!rst_n) begin
      for (int d = 0; d < 4; d++) begin
        mq[d].delete();
        ln[d].delete();
      end
      eOvf = '0;
    end else begin
      for (int d = 0; d < 4; d++) begin
        pre = mq[d].size();
        eOvf[d] = wr_en && (pre == 4);
        if (ln[d].size() != 0) void'(ln[d].pop_front());
        if (ln[d].size() == 0 && pre != 0) begin
          w   = mq[d].pop_front();
          div = (baud_div < 16'd2) ? 2 : int'(baud_div);
          p   = (($countones(w) % 2) == 1) ^ (PM[d] == 2);
          repeat (div) ln[d].push_back(1'b0);
          for (int i = 0; i < DB[d]; i++) repeat (div) ln[d].push_back(w[i]);
          if (PM[d] != 0) repeat (div) ln[d].push_back(p);
          repeat (div * SB[d]) ln[d].push_back(1'b1);
        end
        if (wr_en && pre < 4) mq[d].push_back(wr_data & 8'((1 << DB[d]) - 1));
      end
    end
    for (int d = 0; d < 4; d++) begin
      eTxd[d]   = (ln[d].size() != 0) ? ln[d][0] : 1'b1;
      eBusy[d]  = (ln[d].size() != 0);
      eLvl[d]   = 3'(mq[d].size());
      eFull[d]  = (mq[d].size() == 4);
      eEmpty[d] = (mq[d].size() == 0);
    end
  end

  logic [7:0] obs [4];
  logic [7:0] expv [4];
  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign obs[g]  = {txd[g], busy[g], ovf[g], full[g], empty[g], lvl[g]};
    assign expv[g] = {eTxd[g], eBusy[g], eOvf[g], eFull[g], eEmpty[g], eLvl[g]};
  end

  function automatic int frameLen(input int d, input int div);
    return div * (1 + DB[d] + ((PM[d] != 0) ? 1 : 0) + SB[d]);
  endfunction

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      nChk++;
      if (obs[d] !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0}) begin
        nFail++;
        $display("FAIL reset u%0d txd/busy/ovf/full/empty/lvl=%b expected %b", d, obs[d], 8'b10001000);
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int fall = -1;
    int bc [4] = '{0, 0, 0, 0};
    @(negedge clk);
    baud_div = 16'd4; wr_data = 8'hA5; wr_en = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      wr_en = 1'b0;
      for (int d = 0; d < 4; d++) begin
        nChk++;
        if (obs[d] !== expv[d]) begin
          nFail++;
          $display("FAIL basic u%0d k=%0d got %b expected %b", d, k, obs[d], expv[d]);
        end
        if (busy[d] === 1'b1) bc[d]++;
      end
      if (txd[0] === 1'b0 && fall < 0) fall = k;
    end
    nChk++;
    if (fall !== 2) begin
      nFail++;
      $display("FAIL basic_latency got %0d expected 2", fall);
    end
    nChk++;
    if (bc[0] !== 40) begin
      nFail++;
      $display("FAIL basic_busy_len got %0d expected 40", bc[0]);
    end
    for (int d = 1; d < 4; d++) begin
      nChk++;
      if (bc[d] !== frameLen(d, 4)) begin
        nFail++;
        $display("FAIL basic_len u%0d got %0d expected %0d", d, bc[d], frameLen(d, 4));
      end
    end
  endtask

  task automatic test_parity();
    int bc1 = 0;
    @(negedge clk);
    baud_div = 16'd3; wr_data = 8'h07; wr_en = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      wr_en = 1'b0;
      for (int d = 0; d < 4; d++) begin
        nChk++;
        if (obs[d] !== expv[d]) begin
          nFail++;
          $display("FAIL parity u%0d k=%0d got %b expected %b", d, k, obs[d], expv[d]);
        end
      end
      if (busy[1] === 1'b1) bc1++;
      // frame starts at k=2: start 3, data 24, parity k=29..31, stop k=32..37
      if (k >= 29 && k <= 31) begin
        nChk++;
        if (txd[1] !== 1'b1 || txd[2] !== 1'b0) begin
          nFail++;
          $display("FAIL parity_bit k=%0d even=%b odd=%b expected even=1 odd=0", k, txd[1], txd[2]);
        end
      end
      if (k >= 32 && k <= 37) begin
        nChk++;
        if (txd[1] !== 1'b1) begin
          nFail++;
          $display("FAIL parity_stop k=%0d got %b expected 1", k, txd[1]);
        end
      end
    end
    nChk++;
    if (bc1 !== 36) begin
      nFail++;
      $display("FAIL parity_len got %0d expected 36", bc1);
    end
  endtask

  task automatic test_narrow();
    int bc3 = 0;
    @(negedge clk);
    baud_div = 16'd2; wr_data = 8'h1F; wr_en = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      wr_en = 1'b0;
      for (int d = 0; d < 4; d++) begin
        nChk++;
        if (obs[d] !== expv[d]) begin
          nFail++;
          $display("FAIL narrow u%0d k=%0d got %b expected %b", d, k, obs[d], expv[d]);
        end
      end
      if (busy[3] === 1'b1) bc3++;
    end
    nChk++;
    if (bc3 !== 14) begin
      nFail++;
      $display("FAIL narrow_len got %0d expected 14", bc3);
    end
  endtask

  task automatic test_overflow();
    int ovc = 0, peak = 0, bc0 = 0, drops = 0;
    logic prevBusy = 1'b0;
    @(negedge clk);
    baud_div = 16'd4; wr_data = 8'h11; wr_en = 1'b1;
    for (int k = 1; k <= 260; k++) begin
      @(negedge clk);
      if (k < 6) begin
        wr_en = 1'b1; wr_data = 8'(8'h11 + k);
      end else wr_en = 1'b0;
      for (int d = 0; d < 4; d++) begin
        nChk++;
        if (obs[d] !== expv[d]) begin
          nFail++;
          $display("FAIL overflow u%0d k=%0d got %b expected %b", d, k, obs[d], expv[d]);
        end
      end
      if (ovf[0] === 1'b1) ovc++;
      if (int'(lvl[0]) > peak) peak = int'(lvl[0]);
      if (busy[0] === 1'b1) bc0++;
      if (prevBusy && busy[0] === 1'b0) drops++;
      prevBusy = busy[0];
    end
    nChk++;
    if (ovc !== 1) begin
      nFail++;
      $display("FAIL overflow_pulses got %0d expected 1", ovc);
    end
    nChk++;
    if (peak !== 4) begin
      nFail++;
      $display("FAIL overflow_peak got %0d expected 4", peak);
    end
    nChk++;
    if (bc0 !== 200 || drops !== 1) begin
      nFail++;
      $display("FAIL overflow_contig busy=%0d drops=%0d expected 200 and 1", bc0, drops);
    end
    nChk++;
    if (lvl[0] !== 3'd0) begin
      nFail++;
      $display("FAIL overflow_final_level got %0d expected 0", lvl[0]);
    end
  endtask

  task automatic test_baud_change();
    int bc0 = 0;
    @(negedge clk);
    baud_div = 16'd4; wr_data = 8'($urandom); wr_en = 1'b1;
    for (int k = 1; k <= 160; k++) begin
      @(negedge clk);
      wr_en = (k == 1);
      if (k == 1) wr_data = 8'($urandom);
      if (k == 10) baud_div = 16'd8;
      for (int d = 0; d < 4; d++) begin
        nChk++;
        if (obs[d] !== expv[d]) begin
          nFail++;
          $display("FAIL baud_change u%0d k=%0d got %b expected %b", d, k, obs[d], expv[d]);
        end
      end
      if (busy[0] === 1'b1) bc0++;
    end
    nChk++;
    if (bc0 !== 120) begin
      nFail++;
      $display("FAIL baud_change_len got %0d expected 120", bc0);
    end
    bc0 = 0;
    baud_div = 16'd0; wr_data = 8'($urandom); wr_en = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      wr_en = 1'b0;
      for (int d = 0; d < 4; d++) begin
        nChk++;
        if (obs[d] !== expv[d]) begin
          nFail++;
          $display("FAIL baud_zero u%0d k=%0d got %b expected %b", d, k, obs[d], expv[d]);
        end
      end
      if (busy[0] === 1'b1) bc0++;
    end
    nChk++;
    if (bc0 !== 20) begin
      nFail++;
      $display("FAIL baud_zero_len got %0d expected 20", bc0);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    baud_div = 16'd4;
    for (int k = 0; k < 4; k++) begin
      wr_data = 8'($urandom); wr_en = 1'b1;
      @(negedge clk);
    end
    wr_en = 1'b0;
    repeat (10) @(negedge clk);
    nChk++;
    if (busy[0] !== 1'b1 || empty[0] !== 1'b0) begin
      nFail++;
      $display("FAIL reset_mid_setup busy=%b empty=%b expected busy=1 empty=0", busy[0], empty[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      nChk++;
      if ({txd[d], busy[d], empty[d], lvl[d]} !== {1'b1, 1'b0, 1'b1, 3'd0}) begin
        nFail++;
        $display("FAIL reset_mid u%0d txd/busy/empty/lvl=%b expected %b", d,
                 {txd[d], busy[d], empty[d], lvl[d]}, 6'b101000);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        nChk++;
        if (txd[d] !== 1'b1 || busy[d] !== 1'b0 || obs[d] !== expv[d]) begin
          nFail++;
          $display("FAIL reset_after u%0d k=%0d got %b expected %b", d, k, obs[d], expv[d]);
        end
      end
    end
  endtask

  task automatic test_random();
    bit done = 1'b0;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        nChk++;
        if (obs[d] !== expv[d]) begin
          nFail++;
          $display("FAIL random u%0d k=%0d got %b expected %b", d, k, obs[d], expv[d]);
        end
      end
      wr_en   = ($urandom_range(0, 4) == 0);
      wr_data = 8'($urandom);
      if ($urandom_range(0, 40) == 0) baud_div = 16'($urandom_range(0, 5));
    end
    wr_en = 1'b0;
    for (int k = 1; k <= 3000 && !done; k++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        nChk++;
        if (obs[d] !== expv[d]) begin
          nFail++;
          $display("FAIL drain u%0d k=%0d got %b expected %b", d, k, obs[d], expv[d]);
        end
      end
      if (busy === 4'b0000 && empty === 4'b1111) done = 1'b1;
    end
    nChk++;
    if (!done) begin
      nFail++;
      $display("FAIL drain_timeout busy=%b empty=%b expected 0000 and 1111", busy, empty);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_narrow();
    test_overflow();
    test_baud_change();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end
endmodule
